// File: rtl/packetgen_pkg.sv
// Shared types and constants for the packet generator flow scheduler.
package packetgen_pkg;

    localparam int FRAC_BITS = 16;
    localparam int MIN_SIZE  = 64;
    localparam int MAX_SIZE  = 2047;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after ptr wins, searching upward with wrap.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);
    localparam int IDX_W = $clog2(N);

    logic found;
    int   k;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        k          = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found         = 1'b1;
                gnt_onehot[k] = 1'b1;
                gnt_idx       = IDX_W'(k);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/flow_scheduler.sv
// Per-flow token-bucket rate scheduler with round-robin grant issue.
// Optional per-flow grant counters: define FLOW_SCHED_STATS_EN.
//
//   state | meaning
//   IDLE  | no grant outstanding; latch RR winner if any flow is eligible
//   GRANT | grant_valid high; waiting for grant_ready, then debit and rotate
module flow_scheduler
    import packetgen_pkg::*;
#(
    parameter int N_FLOWS     = 4,
    parameter int RATE_W      = 32,
    parameter int SIZE_W      = 11,
    parameter int BURST_BYTES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(N_FLOWS)-1:0] cfg_flow,
    input  logic                       cfg_en,
    input  logic [RATE_W-1:0]          cfg_rate,
    input  logic [SIZE_W-1:0]          cfg_size,
    output logic                       grant_valid,
    input  logic                       grant_ready,
    output logic [$clog2(N_FLOWS)-1:0] grant_flow,
    output logic [SIZE_W-1:0]          grant_size,
`ifdef FLOW_SCHED_STATS_EN
    input  logic [$clog2(N_FLOWS)-1:0] stat_sel,
    output logic [31:0]                stat_cnt,
`endif
    output logic                       busy
);
    localparam int IDX_W = $clog2(N_FLOWS);
    localparam int BKT_W = FRAC_BITS + $clog2(BURST_BYTES) + 1;
    localparam int SUM_W = ((BKT_W > RATE_W) ? BKT_W : RATE_W) + 1;
    localparam logic [SUM_W-1:0] CAP = SUM_W'(BURST_BYTES) << FRAC_BITS;

    sched_state_t       state;
    logic [N_FLOWS-1:0] en;
    logic [RATE_W-1:0]  rate       [N_FLOWS];
    logic [SIZE_W-1:0]  size       [N_FLOWS];
    logic [BKT_W-1:0]   bucket     [N_FLOWS];
    logic [BKT_W-1:0]   bucket_nxt [N_FLOWS];
    logic [SUM_W-1:0]   sum        [N_FLOWS];
    logic [SUM_W-1:0]   debit      [N_FLOWS];
    logic [N_FLOWS-1:0] elig;
    logic [IDX_W-1:0]   ptr;
    logic [N_FLOWS-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [SIZE_W-1:0]  win_size;
    logic               accept;

    assign accept = grant_valid & grant_ready;
    assign busy   = |en;

    // Debit is clamped at zero so a flow toggled off and on mid-grant cannot wrap.
    always_comb begin
        for (int f = 0; f < N_FLOWS; f++) begin
            debit[f] = (accept && grant_flow == IDX_W'(f))
                       ? (SUM_W'(grant_size) << FRAC_BITS) : '0;
            sum[f] = SUM_W'(bucket[f]) + SUM_W'(rate[f]);
            sum[f] = (sum[f] >= debit[f]) ? (sum[f] - debit[f]) : '0;
            if (sum[f] > CAP) begin
                sum[f] = CAP;
            end
            bucket_nxt[f] = en[f] ? BKT_W'(sum[f]) : '0;
            elig[f] = en[f] && (SUM_W'(bucket[f]) >= (SUM_W'(size[f]) << FRAC_BITS));
        end
    end

    rr_arbiter #(.N(N_FLOWS)) u_arb (
        .req        (elig),
        .ptr        (ptr),
        .gnt_onehot (win_onehot),
        .gnt_idx    (win_idx),
        .any        (win_any)
    );

    always_comb begin
        win_size = '0;
        for (int f = 0; f < N_FLOWS; f++) begin
            if (win_onehot[f]) begin
                win_size = win_size | size[f];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= '0;
            for (int f = 0; f < N_FLOWS; f++) begin
                rate[f]   <= '0;
                size[f]   <= '0;
                bucket[f] <= '0;
            end
        end else begin
            for (int f = 0; f < N_FLOWS; f++) begin
                bucket[f] <= bucket_nxt[f];
            end
            if (cfg_we) begin
                en[cfg_flow]   <= cfg_en;
                rate[cfg_flow] <= cfg_rate;
                size[cfg_flow] <= cfg_size;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_flow  <= '0;
            grant_size  <= '0;
            ptr         <= IDX_W'(N_FLOWS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant_flow  <= win_idx;
                        grant_size  <= win_size;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        ptr         <= grant_flow;
                        state       <= IDLE;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef FLOW_SCHED_STATS_EN
    logic [31:0] grant_cnt [N_FLOWS];

    // A config write to a flow restarts its count, even if it is granted that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < N_FLOWS; f++) begin
                grant_cnt[f] <= '0;
            end
            stat_cnt <= '0;
        end else begin
            for (int f = 0; f < N_FLOWS; f++) begin
                if (cfg_we && cfg_flow == IDX_W'(f)) begin
                    grant_cnt[f] <= '0;
                end else if (accept && grant_flow == IDX_W'(f)) begin
                    grant_cnt[f] <= grant_cnt[f] + 32'd1;
                end
            end
            stat_cnt <= grant_cnt[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_flow_scheduler.sv
// Self-checking bench for flow_scheduler: vector table, directed corner sequences,
// and randomized traffic compared cycle by cycle against a token-bucket model.
`timescale 1ns/100ps
module tb_flow_scheduler;
    localparam int     N   = 4;
    localparam longint CAP = longint'(4096) * 65536;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_flow = '0;
    logic        cfg_en = 1'b0;
    logic [31:0] cfg_rate = '0;
    logic [10:0] cfg_size = '0;
    logic        grant_ready = 1'b0;
    logic        grant_valid;
    logic [1:0]  grant_flow;
    logic [10:0] grant_size;
    logic        busy;
`ifdef FLOW_SCHED_STATS_EN
    logic [1:0]  stat_sel = '0;
    logic [31:0] stat_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    flow_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_flow    (cfg_flow),
        .cfg_en      (cfg_en),
        .cfg_rate    (cfg_rate),
        .cfg_size    (cfg_size),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_flow  (grant_flow),
        .grant_size  (grant_size),
`ifdef FLOW_SCHED_STATS_EN
        .stat_sel    (stat_sel),
        .stat_cnt    (stat_cnt),
`endif
        .busy        (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte credit in 1/65536 units, one pending grant, RR pointer.
    longint m_bkt [N];
    longint m_rate[N];
    int     m_en  [N];
    int     m_size[N];
    int     m_ptr, m_flow, m_gsize;
    bit     m_valid;
    longint nb [N];
    longint deb;
    int     win, k;
    bit     acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < N; f++) begin
                m_bkt[f] = 0; m_rate[f] = 0; m_en[f] = 0; m_size[f] = 0;
            end
            m_ptr = N - 1; m_flow = 0; m_gsize = 0; m_valid = 1'b0;
        end else begin
            acc = m_valid && grant_ready;
            for (int f = 0; f < N; f++) begin
                deb = (acc && m_flow == f) ? longint'(m_gsize) * 65536 : 0;
                if (m_en[f] == 0) nb[f] = 0;
                else begin
                    nb[f] = m_bkt[f] + m_rate[f] - deb;
                    if (nb[f] < 0) nb[f] = 0;
                    if (nb[f] > CAP) nb[f] = CAP;
                end
            end
            win = -1;
            if (!m_valid) begin
                for (int i = 1; i <= N; i++) begin
                    k = (m_ptr + i) % N;
                    if (win < 0 && m_en[k] != 0 && m_bkt[k] >= longint'(m_size[k]) * 65536) win = k;
                end
            end
            if (acc) begin
                m_ptr = m_flow;
                m_valid = 1'b0;
            end
            if (win >= 0) begin
                m_valid = 1'b1;
                m_flow  = win;
                m_gsize = m_size[win];
            end
            for (int f = 0; f < N; f++) m_bkt[f] = nb[f];
            if (cfg_we) begin
                m_en[cfg_flow]   = cfg_en ? 1 : 0;
                m_rate[cfg_flow] = longint'(cfg_rate);
                m_size[cfg_flow] = int'(cfg_size);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("model_valid", longint'(grant_valid), longint'(m_valid));
            check("model_flow",  longint'(grant_flow),  longint'(m_flow));
            check("model_size",  longint'(grant_size),  longint'(m_gsize));
            check("model_busy",  longint'(busy), longint'((m_en[0] | m_en[1] | m_en[2] | m_en[3]) != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_we = 1'b0;
        grant_ready = 1'b0;
        #7;
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int f, input bit e, input longint r, input int s);
        cfg_flow = 2'(f);
        cfg_en   = e;
        cfg_rate = 32'(r);
        cfg_size = 11'(s);
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_grant(input string name, output int n);
        n = 0;
        while (n < 5000) begin
            tick();
            n++;
            if (grant_valid) break;
        end
        check({name, "_seen"}, longint'(grant_valid), 1);
    endtask

    typedef struct {
        int     flow;
        longint rate;
        int     size;
        int     exp_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, bad, seen;

        #3;
        check("rst_valid", longint'(grant_valid), 0);
        check("rst_flow",  longint'(grant_flow), 0);
        check("rst_size",  longint'(grant_size), 0);
        check("rst_busy",  longint'(busy), 0);
        #10;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // first-grant latency = ceil(size/rate_bytes) + 1 edges after the config write
        tbl[0] = '{0, 64'h0001_0000,   64,  65};
        tbl[1] = '{1, 64'h0002_0000,   64,  33};
        tbl[2] = '{2, 64'h0000_8000,  100, 201};
        tbl[3] = '{3, 64'h0100_0000,   64,   2};
        tbl[4] = '{3, 64'h0001_8000,  100,  68};
        tbl[5] = '{1, 64'h0010_0000, 2047, 129};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            cfg_write(tbl[i].flow, 1'b1, tbl[i].rate, tbl[i].size);
            wait_grant("tbl", n);
            check("tbl_latency", n, tbl[i].exp_lat);
            check("tbl_flow", longint'(grant_flow), tbl[i].flow);
            check("tbl_size", longint'(grant_size), tbl[i].size);
        end

        // 1 B/cycle, size 64, ready tied high: grants every 64 cycles
        do_reset();
        grant_ready = 1'b1;
        cfg_write(0, 1'b1, 64'h0001_0000, 64);
        wait_grant("p1_first", n);
        check("p1_first_lat", n, 65);
        for (int g = 0; g < 3; g++) begin
            wait_grant("p1_next", n);
            check("p1_interval", n, 64);
            check("p1_flow", longint'(grant_flow), 0);
            check("p1_size", longint'(grant_size), 64);
        end

        // all flows saturated: strict 0,1,2,3 rotation, one grant every 2 cycles
        do_reset();
        for (int f = 0; f < N; f++) cfg_write(f, 1'b1, 64'h0100_0000, 64);
        check("p2_pending_valid", longint'(grant_valid), 1);
        check("p2_pending_flow", longint'(grant_flow), 0);
        grant_ready = 1'b1;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (t <= 24) begin
                check("p2_valid_pattern", longint'(grant_valid), longint'(t % 2 == 0));
                if (grant_valid) check("p2_rr_order", longint'(grant_flow), (t / 2) % 4);
            end
        end
        grant_ready = 1'b0;
`ifdef FLOW_SCHED_STATS_EN
        for (int f = 0; f < N; f++) begin
            stat_sel = 2'(f);
            tick();
            check("stat_cnt", longint'(stat_cnt), 25);
        end
`endif

        // held grant for 1000 cycles: stable output, bucket pinned at the cap
        do_reset();
        cfg_write(1, 1'b1, 64'h0010_0000, 64);
        bad = 0;
        seen = 0;
        for (int t = 0; t < 1000; t++) begin
            tick();
            if (grant_valid) seen = 1;
            if (seen != 0 && !(grant_valid && grant_flow == 2'd1 && grant_size == 11'd64)) bad++;
        end
        check("p3_seen", seen, 1);
        check("p3_unstable_cycles", bad, 0);
        check("p3_bucket_cap", longint'(dut.bucket[1]), CAP);

        // granted flow disabled while waiting: grant survives, no debit, no more grants
        do_reset();
        cfg_write(2, 1'b1, 64'h0100_0000, 100);
        wait_grant("p4", n);
        check("p4_flow", longint'(grant_flow), 2);
        cfg_write(2, 1'b0, 64'h0100_0000, 500);
        tick();
        tick();
        check("p4_still_valid", longint'(grant_valid), 1);
        check("p4_size_kept", longint'(grant_size), 100);
        check("p4_busy", longint'(busy), 0);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        check("p4_accepted", longint'(grant_valid), 0);
        check("p4_bucket_zero", longint'(dut.bucket[2]), 0);
        grant_ready = 1'b1;
        bad = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (grant_valid) bad++;
        end
        grant_ready = 1'b0;
        check("p4_no_more_grants", bad, 0);

        // async reset mid-grant
        do_reset();
        cfg_write(0, 1'b1, 64'h0100_0000, 64);
        wait_grant("p5", n);
        #3;
        rst_n = 1'b0;
        #1;
        check("p5_valid_cleared", longint'(grant_valid), 0);
        check("p5_busy_cleared", longint'(busy), 0);
        check("p5_size_cleared", longint'(grant_size), 0);
        check("p5_bucket_cleared", longint'(dut.bucket[0]), 0);
        #0.5;
        rst_n = 1'b1;
        cfg_write(0, 1'b1, 64'h0001_0000, 64);
        wait_grant("p5_restart", n);
        check("p5_restart_lat", n, 65);

        // randomized traffic against the model
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            cfg_we   = ($urandom % 8 == 0);
            cfg_flow = 2'($urandom % 4);
            cfg_en   = ($urandom % 4 != 0);
            case ($urandom % 3)
                0:       cfg_rate = $urandom % 32'h0004_0000;
                1:       cfg_rate = $urandom % 32'h0080_0000;
                default: cfg_rate = $urandom;
            endcase
            cfg_size    = 11'(64 + $urandom % 1984);
            grant_ready = ($urandom % 3 != 0);
            tick();
        end
        cfg_we = 1'b0;
        grant_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
